mux2_rr_arbiter: RTL and testbench
==================================

Name: mux2_rr_arbiter

Overview:
Round-robin arbiter and sequencer for a shared registered 2:1 mux datapath. Two requesters (A, B) compete for the output register.
- The block grants one requester at a time and drives the mux select from the grant.
- It captures the granted input into the output register and flags valid data.
- It enforces a maximum hold time so neither requester can starve the other.

Parameters:
WIDTH, 1, data width of inputs a, b and output q
MAX_HOLD, 4, max consecutive granted cycles for one owner while the other requests (legal range >=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
req_a  input  1  requester A wants the datapath
req_b  input  1  requester B wants the datapath
a  input  WIDTH  data from requester A
b  input  WIDTH  data from requester B
gnt_a  output  1  A owns datapath this cycle (registered)
gnt_b  output  1  B owns datapath this cycle (registered)
sel  output  1  mux select, equals gnt_b (0 = a, 1 = b)
q  output  WIDTH  registered mux output
q_valid  output  1  q holds a sample captured during a valid granted cycle
q_src  output  1  source of current q (0 = A, 1 = B)

Behaviour:
- Reset (async, immediate, also mid-operation): state IDLE; gnt_a, gnt_b, sel, q, q_valid, q_src = 0; hold counter cnt = 0; last-served pointer = B, so A wins the first tie.
- All outputs are registered. gnt_a and gnt_b are never both 1.
- States:
  - IDLE: no grant.
  - OWN_A: gnt_a = 1.
  - OWN_B: gnt_b = 1.
- IDLE transitions, evaluated at each rising edge:
  - both req -> owner is the side not equal to last.
  - one req -> that side.
  - none -> stay in IDLE.
- OWN_X transitions, with Y the other side:
  - !req_x & req_y -> OWN_Y.
  - !req_x & !req_y -> IDLE.
  - req_x & req_y & cnt==MAX_HOLD-1 -> OWN_Y (forced handover).
  - otherwise stay in OWN_X.
- Handover is direct OWN_A <-> OWN_B with no idle bubble.
- cnt rules:
  - cleared to 0 on every grant change.
  - incremented each cycle the owner stays.
  - saturates at MAX_HOLD-1 while the other side is not requesting, so the owner keeps the grant indefinitely if uncontested.
- last updates to the new owner on every entry into OWN_A or OWN_B.
- MAX_HOLD=1: strict alternation every cycle while both request.
- Latency:
  - req rises in cycle N (IDLE) -> gnt high in cycle N+1.
  - Data present on a/b in cycle N+1 -> q updated in cycle N+2.
- Datapath, at each edge:
  - if (gnt_a & req_a) | (gnt_b & req_b): q <= sel ? b : a; q_src <= sel; q_valid <= 1.
  - else: q and q_src hold; q_valid <= 0.
- A requester that drops req while still granted contributes no sample that cycle.
- Simultaneous drop of req_x and rise of req_y while owning X: switch to Y at that edge; no valid sample from X.

Test Plan:
- Reset: assert rst mid-grant with q=1, q_valid=1 -> all outputs 0 immediately, before the next clk edge. Release, then req_a=req_b=1 -> gnt_a first.
- Single requester: req_a=1 from cycle 2, a=1 -> gnt_a=1 in cycle 3, q=1, q_valid=1, q_src=0 in cycle 4. req_a=0 -> IDLE next cycle, q_valid=0, q holds 1.
- Fairness, MAX_HOLD=4: req_a=req_b=1 continuously, a=1, b=0 -> gnt_a for 4 cycles, then gnt_b for 4 cycles, repeating. q follows a/b one cycle after each grant.
- Uncontested hold: req_a=1 for 10 cycles, req_b=0 -> gnt_a stays 1 for all 10 cycles. Raise req_b -> grant moves to B exactly at the edge where cnt==3.
- Early release: owning A with cnt=1, req_a falls while req_b=1 -> gnt_b=1 next cycle with no idle cycle. The cycle of the drop produces q_valid=0.
- MAX_HOLD=1: both requesting -> grants alternate A, B, A, B every cycle. q_src toggles each cycle after a one-cycle lag.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared registered 2:1 mux.
// Ports:
//   clk, rst          rising-edge clock, async active-high reset
//   req_a, req_b      requests from sides A and B
//   a, b              data from sides A and B
//   gnt_a, gnt_b      registered grants (never both high)
//   sel               mux select, equals gnt_b
//   q, q_valid, q_src registered mux output, valid flag, source side
module mux2_rr_arbiter #(
   parameter int WIDTH    = 1,
   parameter int MAX_HOLD = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_a,
   input  logic             req_b,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             gnt_a,
   output logic             gnt_b,
   output logic             sel,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   output logic             q_src
);

   localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CW-1:0] CMAX = CW'(MAX_HOLD - 1);

   // One-hot style encoding so the grants come straight off the state flops.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      OWN_A = 2'b01,
      OWN_B = 2'b10
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          last, last_nx;  // last served side: 0 = A, 1 = B

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         last  <= 1'b1;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         last  <= last_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      last_nx  = last;
      unique case (state)
         IDLE: begin
            if (req_a && req_b)
               state_nx = last ? OWN_A : OWN_B;
            else if (req_a)
               state_nx = OWN_A;
            else if (req_b)
               state_nx = OWN_B;
         end
         OWN_A: begin
            if (!req_a)
               state_nx = req_b ? OWN_B : IDLE;
            else if (req_b && cnt == CMAX)
               state_nx = OWN_B;
         end
         OWN_B: begin
            if (!req_b)
               state_nx = req_a ? OWN_A : IDLE;
            else if (req_a && cnt == CMAX)
               state_nx = OWN_A;
         end
         default: state_nx = IDLE;
      endcase

      // Saturating at CMAX lets an uncontested owner keep the grant while
      // still allowing an immediate handover once the other side asks.
      if (state_nx != state)
         cnt_nx = '0;
      else if (state != IDLE && cnt != CMAX)
         cnt_nx = cnt + 1'b1;

      if (state_nx == OWN_A && state != OWN_A)
         last_nx = 1'b0;
      else if (state_nx == OWN_B && state != OWN_B)
         last_nx = 1'b1;
   end

   assign gnt_a = state[0];
   assign gnt_b = state[1];
   assign sel   = gnt_b;

   // A side that drops its request while still granted gives no sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q       <= '0;
         q_valid <= 1'b0;
         q_src   <= 1'b0;
      end else if ((gnt_a && req_a) || (gnt_b && req_b)) begin
         q       <= sel ? b : a;
         q_src   <= sel;
         q_valid <= 1'b1;
      end else begin
         q_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: two instances (MAX_HOLD 4 and 1) share stimulus
// and are compared every cycle against a behavioural model.
module tb_mux2_rr_arbiter;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_a, req_b;
   logic [W-1:0] a, b;

   logic [1:0]   ga, gb, sl, qv, qs;
   logic [W-1:0] qq [2];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mux2_rr_arbiter #(.WIDTH(W), .MAX_HOLD(4)) dut0 (
      .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
      .a(a), .b(b), .gnt_a(ga[0]), .gnt_b(gb[0]), .sel(sl[0]),
      .q(qq[0]), .q_valid(qv[0]), .q_src(qs[0])
   );

   mux2_rr_arbiter #(.WIDTH(W), .MAX_HOLD(1)) dut1 (
      .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
      .a(a), .b(b), .gnt_a(ga[1]), .gnt_b(gb[1]), .sel(sl[1]),
      .q(qq[1]), .q_valid(qv[1]), .q_src(qs[1])
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Model: owner 0 = none, 1 = A, 2 = B; run = cycles held since entry.
   int           mh   [2] = '{4, 1};
   int           own  [2] = '{0, 0};
   int           run  [2] = '{0, 0};
   bit           lastb[2] = '{1'b1, 1'b1};
   logic [W-1:0] mq   [2] = '{'0, '0};
   bit           mqv  [2] = '{1'b0, 1'b0};
   bit           msrc [2] = '{1'b0, 1'b0};

   always @(posedge clk or posedge rst) begin : model
      int nxt;
      bit mine, oth;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            own[k] = 0; run[k] = 0; lastb[k] = 1'b1;
            mq[k] = '0; mqv[k] = 1'b0; msrc[k] = 1'b0;
         end else begin
            if (own[k] == 1 && req_a) begin
               mq[k] = a; msrc[k] = 1'b0; mqv[k] = 1'b1;
            end else if (own[k] == 2 && req_b) begin
               mq[k] = b; msrc[k] = 1'b1; mqv[k] = 1'b1;
            end else begin
               mqv[k] = 1'b0;
            end
            nxt = own[k];
            if (own[k] == 0) begin
               if (req_a && req_b) nxt = lastb[k] ? 1 : 2;
               else if (req_a)     nxt = 1;
               else if (req_b)     nxt = 2;
            end else begin
               mine = (own[k] == 1) ? req_a : req_b;
               oth  = (own[k] == 1) ? req_b : req_a;
               if (!mine)
                  nxt = oth ? 3 - own[k] : 0;
               else if (oth && run[k] + 1 >= mh[k])
                  nxt = 3 - own[k];
            end
            if (nxt != own[k]) run[k] = 0;
            else if (own[k] != 0) run[k]++;
            if (nxt != 0 && nxt != own[k]) lastb[k] = (nxt == 2);
            own[k] = nxt;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("m%0d_gnt_a", k), ga[k], own[k] == 1);
            chk($sformatf("m%0d_gnt_b", k), gb[k], own[k] == 2);
            chk($sformatf("m%0d_sel", k), sl[k], own[k] == 2);
            chk($sformatf("m%0d_q_valid", k), qv[k], mqv[k]);
            chk($sformatf("m%0d_q_src", k), qs[k], msrc[k]);
            chk($sformatf("m%0d_q", k), qq[k], mq[k]);
         end
      end
   end

   logic [15:0] h0, h1, s1;
   logic        hold;

   initial begin
      rst = 1'b1; req_a = 1'b0; req_b = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("rst_gnt_a", ga[0], 0);
      chk("rst_q", qq[0], 0);
      chk("rst_q_valid", qv[0], 0);

      // single requester
      req_a = 1'b1; a = 4'h1;
      @(negedge clk);
      chk("single_gnt_a", ga[0], 1);
      chk("single_qv_lag", qv[0], 0);
      @(negedge clk);
      chk("single_q", qq[0], 4'h1);
      chk("single_qv", qv[0], 1);
      chk("single_src", qs[0], 0);
      req_a = 1'b0; a = 4'h6;
      @(negedge clk);
      chk("release_gnt_a", ga[0], 0);
      chk("release_qv", qv[0], 0);
      chk("release_q_hold", qq[0], 4'h1);

      // async reset in the middle of a grant
      req_a = 1'b1; a = 4'h1;
      repeat (2) @(negedge clk);
      chk("pre_rst_qv", qv[0], 1);
      #2 rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("arst%0d_gnt_a", k), ga[k], 0);
         chk($sformatf("arst%0d_gnt_b", k), gb[k], 0);
         chk($sformatf("arst%0d_sel", k), sl[k], 0);
         chk($sformatf("arst%0d_q", k), qq[k], 0);
         chk($sformatf("arst%0d_qv", k), qv[k], 0);
         chk($sformatf("arst%0d_src", k), qs[k], 0);
      end
      @(negedge clk);
      #2 rst = 1'b0;
      req_a = 1'b1; req_b = 1'b1; a = 4'h1; b = 4'h0;

      // fairness, both sides requesting
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         h0[i] = gb[0];
         h1[i] = gb[1];
         s1[i] = qs[1];
      end
      chk("fair_mh4_gnt_b", h0, 16'hF0F0);
      chk("fair_mh1_gnt_b", h1, 16'hAAAA);
      chk("fair_mh1_src", s1, 16'h5554);

      // uncontested hold by A
      req_b = 1'b0; req_a = 1'b1;
      hold = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         hold = hold & ga[0];
         a = 4'(i);
      end
      chk("hold_10", hold, 1);
      req_b = 1'b1;
      @(negedge clk);
      chk("hold_handover_mh4", gb[0], 1);
      chk("hold_handover_mh1", gb[1], 1);

      // early release at cnt 1
      req_a = 1'b1; req_b = 1'b0; a = 4'hC;
      @(negedge clk);
      chk("early_gnt_a0", ga[0], 1);
      req_b = 1'b1; b = 4'h3;
      @(negedge clk);
      chk("early_gnt_a1", ga[0], 1);
      req_a = 1'b0;
      @(negedge clk);
      chk("early_gnt_b", gb[0], 1);
      chk("early_qv", qv[0], 0);

      // simultaneous drop of B and rise of A
      req_b = 1'b0; req_a = 1'b1; a = 4'h9;
      @(negedge clk);
      chk("swap_gnt_a", ga[0], 1);
      chk("swap_qv", qv[0], 0);

      req_a = 1'b0;
      repeat (3) @(negedge clk);
      chk("end_idle", ga[0] | gb[0], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
